// File: rtl/cello_lut_pkg.sv
// Shared types and helpers for the cello_lut_eval truth-table evaluator.
// Contents:
//   state_e    - evaluator FSM states (SETTLE, STABLE, REEVAL)
//   row_index  - maps an input vector to its truth-table bit position
//   defaults   - default input count and settle length, plus the widths derived from them
package cello_lut_pkg;

   localparam int N_IN_DEFAULT          = 3;
   localparam int SETTLE_CYCLES_DEFAULT = 4;
   localparam int MAX_N                 = 6;
   localparam int TBL_W                 = 2**N_IN_DEFAULT;
   localparam int CNT_W                 = $clog2(SETTLE_CYCLES_DEFAULT + 1);

   typedef enum logic [1:0] {
      SETTLE = 2'd0,
      STABLE = 2'd1,
      REEVAL = 2'd2
   } state_e;

   // The table is stored with the all-zero row in the MSB, so the bit
   // position of a row is the row number mirrored: 2**n - 1 - vec.
   function automatic logic [MAX_N-1:0] row_index(input int unsigned n,
                                                  input logic [MAX_N-1:0] vec);
      logic [MAX_N-1:0] all_ones;
      all_ones = MAX_N'((1 << n) - 1);
      return all_ones - vec;
   endfunction

endpackage

// File: rtl/cello_lut_eval_input_settle_filter.sv
// Input settle filter: registers the input vector every edge and accepts it
// once it has held steady for SETTLE_CYCLES consecutive edges while counting
// is enabled.
// Ports:
//   clk, rst   - clock, async active-high reset
//   in_vec     - raw input vector (synchronous to clk)
//   count_en   - high while the evaluator is settling; freezes the timer otherwise
//   changed    - in_vec differs from the previous sample (combinational)
//   accept     - one-cycle pulse: in_vec is accepted on this edge
//   acc_vec    - last accepted input vector
module input_settle_filter
   import cello_lut_pkg::*;
#(
   parameter int N_IN          = N_IN_DEFAULT,
   parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_IN-1:0] in_vec,
   input  logic            count_en,
   output logic            changed,
   output logic            accept,
   output logic [N_IN-1:0] acc_vec
);

   localparam int CNT_BITS = $clog2(SETTLE_CYCLES + 1);
   // Down-counter reload value: edges still needed after the first sample.
   localparam logic [CNT_BITS-1:0] TERM = CNT_BITS'(SETTLE_CYCLES - 1);

   logic [N_IN-1:0]     in_q_q, in_q_d;
   logic [CNT_BITS-1:0] remain_q, remain_d;
   logic [N_IN-1:0]     acc_q, acc_d;

   always_comb begin
      in_q_d   = in_vec;
      remain_d = remain_q;
      acc_d    = acc_q;
      changed  = (in_vec != in_q_q);
      accept   = 1'b0;

      if (changed) begin
         remain_d = TERM;
      end else if (count_en) begin
         if (remain_q == '0) begin
            accept = 1'b1;
            acc_d  = in_vec;
         end else begin
            remain_d = remain_q - CNT_BITS'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_q_q   <= '0;
         remain_q <= TERM;
         acc_q    <= '0;
      end else begin
         in_q_q   <= in_q_d;
         remain_q <= remain_d;
         acc_q    <= acc_d;
      end
   end

   assign acc_vec = acc_q;

endmodule

// File: rtl/cello_lut_eval.sv
// Reconfigurable N-input truth-table evaluator with input settle filter,
// runtime table load and an output-change event stream.
// Ports:
//   clk, rst              - clock, async active-high reset
//   in_vec                - input vector, in_vec[N_IN-1] is the row MSB
//   cfg_valid/cfg_ready   - table load handshake, cfg_table is the new table
//   out                   - registered evaluated output
//   evt_valid/evt_ready   - output-change event handshake
//   evt_data              - {new out, accepted input vector}
//   evt_overrun           - sticky: a pending event was overwritten
//
// state  | meaning
// -------+------------------------------------------------------------
// SETTLE | counting input stability
// STABLE | input accepted, waiting for a change
// REEVAL | one cycle after a table load; re-looks-up acc_vec, then
//        | returns to the remembered prior state
module cello_lut_eval
   import cello_lut_pkg::*;
#(
   parameter int                   N_IN          = N_IN_DEFAULT,
   parameter int                   SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT,
   parameter logic [2**N_IN-1:0]   INIT_TABLE    = 8'h6B
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N_IN-1:0]     in_vec,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [2**N_IN-1:0]  cfg_table,
   output logic                out,
   output logic                evt_valid,
   input  logic                evt_ready,
   output logic [N_IN:0]       evt_data,
   output logic                evt_overrun
);

   localparam int TBL_BITS = 2**N_IN;

   state_e              state_q, state_d;
   state_e              prior_q, prior_d;
   logic [TBL_BITS-1:0] table_q, table_d;
   logic                out_q, out_d;
   logic                evt_valid_q, evt_valid_d;
   logic [N_IN:0]       evt_data_q, evt_data_d;
   logic                evt_overrun_q, evt_overrun_d;

   logic                count_en;
   logic                changed;
   logic                accept;
   logic [N_IN-1:0]     acc_vec;
   logic [N_IN-1:0]     acc_next;
   logic [N_IN-1:0]     row_in;
   logic [N_IN-1:0]     row_acc;
   state_e              resume;

   assign count_en  = (state_q == SETTLE);
   assign cfg_ready = (state_q != REEVAL);
   assign row_in    = N_IN'(row_index(N_IN, MAX_N'(in_vec)));
   assign row_acc   = N_IN'(row_index(N_IN, MAX_N'(acc_vec)));

   input_settle_filter #(
      .N_IN          (N_IN),
      .SETTLE_CYCLES (SETTLE_CYCLES)
   ) u_filter (
      .clk      (clk),
      .rst      (rst),
      .in_vec   (in_vec),
      .count_en (count_en),
      .changed  (changed),
      .accept   (accept),
      .acc_vec  (acc_vec)
   );

   always_comb begin
      state_d       = state_q;
      prior_d       = prior_q;
      table_d       = table_q;
      out_d         = out_q;
      evt_valid_d   = evt_valid_q;
      evt_data_d    = evt_data_q;
      evt_overrun_d = evt_overrun_q;
      acc_next      = accept ? in_vec : acc_vec;
      resume        = (state_q == REEVAL) ? prior_q : state_q;

      // Acceptance only happens in SETTLE, so it never collides with REEVAL.
      if (state_q == REEVAL) begin
         out_d = table_q[row_acc];
      end
      if (accept) begin
         out_d  = table_q[row_in];
         resume = STABLE;
      end
      // An input change wins over whatever state we would otherwise resume.
      if (changed) begin
         resume = SETTLE;
      end
      state_d = resume;

      // A load on an accepting edge remembers STABLE, so the follow-up
      // re-evaluation uses the freshly accepted vector.
      if (cfg_valid && cfg_ready) begin
         table_d = cfg_table;
         prior_d = resume;
         state_d = REEVAL;
      end

      if (out_d != out_q) begin
         if (evt_valid_q && !evt_ready) begin
            evt_overrun_d = 1'b1;
         end
         evt_valid_d = 1'b1;
         evt_data_d  = {out_d, acc_next};
      end else if (evt_valid_q && evt_ready) begin
         evt_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= SETTLE;
         prior_q       <= SETTLE;
         table_q       <= INIT_TABLE;
         out_q         <= INIT_TABLE[TBL_BITS-1];
         evt_valid_q   <= 1'b0;
         evt_data_q    <= '0;
         evt_overrun_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         prior_q       <= prior_d;
         table_q       <= table_d;
         out_q         <= out_d;
         evt_valid_q   <= evt_valid_d;
         evt_data_q    <= evt_data_d;
         evt_overrun_q <= evt_overrun_d;
      end
   end

   assign out         = out_q;
   assign evt_valid   = evt_valid_q;
   assign evt_data    = evt_data_q;
   assign evt_overrun = evt_overrun_q;

endmodule

// File: tb/tb_cello_lut_eval.sv
// Self-checking bench for cello_lut_eval: directed steps followed by random
// stimulus, compared against a behavioural reference model.
module tb_cello_lut_eval;

   localparam int       N    = 3;
   localparam int       S    = 4;
   localparam int       TW   = 8;
   localparam bit [7:0] INIT = 8'h6B;

   logic         clk;
   logic         rst;
   logic [N-1:0] in_vec;
   logic         cfg_valid;
   logic         cfg_ready;
   logic [TW-1:0] cfg_table;
   logic         out;
   logic         evt_valid;
   logic         evt_ready;
   logic [N:0]   evt_data;
   logic         evt_overrun;

   int checks;
   int failures;

   cello_lut_eval #(
      .N_IN          (N),
      .SETTLE_CYCLES (S),
      .INIT_TABLE    (INIT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_vec      (in_vec),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .cfg_table   (cfg_table),
      .out         (out),
      .evt_valid   (evt_valid),
      .evt_ready   (evt_ready),
      .evt_data    (evt_data),
      .evt_overrun (evt_overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: phase 0 = settling, 1 = stable, 2 = one cycle after load.
   bit [7:0] m_table;
   bit       m_out;
   bit [2:0] m_acc;
   bit [2:0] m_last;
   int       m_held;
   int       m_phase;
   int       m_back;
   bit       m_ev;
   bit [3:0] m_ed;
   bit       m_ovr;

   function automatic bit lut(input bit [7:0] t, input int row);
      return ((t >> (TW - 1 - row)) & 8'h01) != 8'h00;
   endfunction

   task automatic model_reset();
      m_table = INIT;
      m_out   = INIT[7];
      m_acc   = 3'd0;
      m_last  = 3'd0;
      m_held  = 0;
      m_phase = 0;
      m_back  = 0;
      m_ev    = 1'b0;
      m_ed    = 4'd0;
      m_ovr   = 1'b0;
   endtask

   task automatic model_edge();
      bit       rdy;
      bit       nout;
      bit [2:0] nacc;
      int       nphase;
      rdy    = (m_phase != 2);
      nout   = m_out;
      nacc   = m_acc;
      nphase = m_phase;
      if (m_phase == 2) begin
         nout   = lut(m_table, int'(m_acc));
         nphase = m_back;
      end
      if (in_vec != m_last) begin
         m_held = 0;
         nphase = 0;
      end else if (m_phase == 0) begin
         if (m_held == S - 1) begin
            nacc   = in_vec;
            nout   = lut(m_table, int'(in_vec));
            nphase = 1;
         end else begin
            m_held = m_held + 1;
         end
      end
      if (cfg_valid && rdy) begin
         m_back  = nphase;
         nphase  = 2;
         m_table = cfg_table;
      end
      if (nout != m_out) begin
         if (m_ev && !evt_ready) m_ovr = 1'b1;
         m_ev = 1'b1;
         m_ed = {nout, nacc};
      end else if (m_ev && evt_ready) begin
         m_ev = 1'b0;
      end
      m_out   = nout;
      m_acc   = nacc;
      m_phase = nphase;
      m_last  = in_vec;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_model(input string tag);
      check({tag, ".out"},       32'(out),         32'(m_out));
      check({tag, ".evt_valid"}, 32'(evt_valid),   32'(m_ev));
      check({tag, ".evt_data"},  32'(evt_data),    32'(m_ed));
      check({tag, ".overrun"},   32'(evt_overrun), 32'(m_ovr));
      check({tag, ".cfg_ready"}, 32'(cfg_ready),   32'(m_phase != 2));
   endtask

   task automatic step(input string tag, input bit [2:0] v, input bit cv,
                       input bit [7:0] ct, input bit er);
      in_vec    = v;
      cfg_valid = cv;
      cfg_table = ct;
      evt_ready = er;
      model_edge();
      @(posedge clk);
      #1;
      check_model(tag);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, ".out"},       32'(out),         32'(INIT[7]));
      check({tag, ".evt_valid"}, 32'(evt_valid),   32'd0);
      check({tag, ".evt_data"},  32'(evt_data),    32'd0);
      check({tag, ".overrun"},   32'(evt_overrun), 32'd0);
      check({tag, ".cfg_ready"}, 32'(cfg_ready),   32'd1);
   endtask

   task automatic pulse_reset(input string tag);
      #2 rst = 1'b1;
      #1 check_reset_values(tag);
      #2 rst = 1'b0;
      model_reset();
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      rst       = 1'b1;
      in_vec    = '0;
      cfg_valid = 1'b0;
      cfg_table = '0;
      evt_ready = 1'b0;
      model_reset();
      #3 check_reset_values("reset");
      #9 rst = 1'b0;

      // Idle hold of 000: acceptance reproduces the reset output, no event.
      for (int i = 0; i < 10; i++) step("idle", 3'b000, 1'b0, 8'h00, 1'b0);
      check("idle_no_event", 32'(evt_valid), 32'd0);

      // 000 -> 001: accepted on the fifth edge after the change.
      for (int i = 0; i < 4; i++) step("settle", 3'b001, 1'b0, 8'h00, 1'b0);
      check("latency_early", 32'(out), 32'd0);
      step("settle", 3'b001, 1'b0, 8'h00, 1'b0);
      check("latency_out", 32'(out), 32'd1);
      check("latency_evt", 32'(evt_data), 32'h9);
      step("consume", 3'b001, 1'b0, 8'h00, 1'b1);
      check("consume_valid", 32'(evt_valid), 32'd0);

      // Back to 000, consume its event, then a short 010 glitch.
      for (int i = 0; i < 6; i++) step("back0", 3'b000, 1'b0, 8'h00, 1'b0);
      step("back0_ack", 3'b000, 1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 2; i++) step("glitch", 3'b010, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 6; i++) step("glitch_end", 3'b000, 1'b0, 8'h00, 1'b0);
      check("glitch_out", 32'(out), 32'd0);
      check("glitch_no_event", 32'(evt_valid), 32'd0);

      // Table load with 000 accepted.
      step("load", 3'b000, 1'b1, 8'h94, 1'b0);
      check("load_busy", 32'(cfg_ready), 32'd0);
      step("reeval", 3'b000, 1'b0, 8'h00, 1'b0);
      check("reeval_out", 32'(out), 32'd1);
      check("reeval_evt", 32'(evt_data), 32'h8);
      check("reeval_ready", 32'(cfg_ready), 32'd1);

      // Overrun: two output changes without a consumer.
      pulse_reset("reset2");
      for (int i = 0; i < 5; i++) step("ovr_a", 3'b001, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 5; i++) step("ovr_b", 3'b011, 1'b0, 8'h00, 1'b0);
      check("ovr_data", 32'(evt_data), 32'h3);
      check("ovr_flag", 32'(evt_overrun), 32'd1);
      for (int i = 0; i < 3; i++) step("ovr_sticky", 3'b011, 1'b0, 8'h00, 1'b1);
      check("ovr_sticky_flag", 32'(evt_overrun), 32'd1);

      // Reset mid-settle during a reload restores the initial table.
      step("mid_a", 3'b101, 1'b0, 8'h00, 1'b0);
      step("mid_b", 3'b101, 1'b1, 8'h94, 1'b0);
      pulse_reset("reset_mid");
      for (int i = 0; i < 5; i++) step("after_rst", 3'b001, 1'b0, 8'h00, 1'b0);
      check("after_rst_table", 32'(out), 32'd1);

      // Random traffic with loads, varying hold lengths and consumer stalls.
      for (int burst = 0; burst < 80; burst++) begin
         bit [2:0] v;
         int       hold;
         v    = 3'($urandom_range(0, 7));
         hold = $urandom_range(1, 7);
         for (int i = 0; i < hold; i++) begin
            step("rand", v, ($urandom_range(0, 11) == 0), 8'($urandom),
                 ($urandom_range(0, 3) != 0));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
